// File: rtl/computie_uart_tx.sv
// Byte FIFO feeding an asynchronous serial transmitter: 8N1 frames by default,
// 8E1 frames when COMPUTIE_UART_TX_PARITY_EN is defined.
module computie_uart_tx #(
  parameter int CLOCK_FREQ = 12000000,
  parameter int BAUD       = 115200,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                          comm_clock,
  input  logic                          comm_reset_n,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [7:0]                    in_data,
  output logic                          tx,
  output logic                          busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

  localparam int DIV_RAW = CLOCK_FREQ / BAUD;
  localparam int DIVIDER = (DIV_RAW < 1) ? 1 : DIV_RAW;
  localparam int TMR_W   = (DIVIDER > 1) ? $clog2(DIVIDER) : 1;
  localparam int PTR_W   = $clog2(FIFO_DEPTH);
  localparam int CNT_W   = PTR_W + 1;

  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(DIVIDER - 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(FIFO_DEPTH);

`ifdef COMPUTIE_UART_TX_PARITY_EN
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_e;
`else
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_e;
`endif

  logic [7:0]       mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  state_e           state_q, state_d;
  logic [TMR_W-1:0] tmr_q, tmr_d;
  logic [2:0]       bit_q, bit_d;
  logic [7:0]       shift_q, shift_d;
  logic             tx_q, tx_d;
`ifdef COMPUTIE_UART_TX_PARITY_EN
  logic             par_q, par_d;
`endif

  logic       push;
  logic       pop;
  logic       fifo_nonempty;
  logic       bit_end;
  logic [7:0] head;

  // Readiness depends only on registered occupancy, so a full FIFO refuses a
  // push even on the cycle it is being popped.
  assign in_ready      = (cnt_q != CNT_FULL);
  assign push          = in_valid && in_ready;
  assign fifo_nonempty = (cnt_q != '0);
  assign head          = mem_q[rd_ptr_q];
  assign bit_end       = (tmr_q == TMR_LAST);

  assign tx         = tx_q;
  assign busy       = (state_q != IDLE) || fifo_nonempty;
  assign fifo_count = cnt_q;

  always_ff @(posedge comm_clock) begin
    if (push) begin
      mem_q[wr_ptr_q] <= in_data;
    end
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (push) begin
      wr_ptr_d = wr_ptr_q + 1'b1;
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    case ({push, pop})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
  end

  always_comb begin
    state_d = state_q;
    tmr_d   = tmr_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    tx_d    = tx_q;
    pop     = 1'b0;
`ifdef COMPUTIE_UART_TX_PARITY_EN
    par_d   = par_q;
`endif
    if (state_q != IDLE) begin
      tmr_d = bit_end ? '0 : tmr_q + 1'b1;
    end

    case (state_q)
      IDLE: begin
        tx_d = 1'b1;
        if (fifo_nonempty) begin
          pop     = 1'b1;
          shift_d = head;
`ifdef COMPUTIE_UART_TX_PARITY_EN
          par_d   = ^head;
`endif
          tx_d    = 1'b0;
          tmr_d   = '0;
          state_d = START;
        end
      end
      START: begin
        if (bit_end) begin
          tx_d    = shift_q[0];
          bit_d   = '0;
          state_d = DATA;
        end
      end
      DATA: begin
        if (bit_end) begin
          if (bit_q == 3'd7) begin
`ifdef COMPUTIE_UART_TX_PARITY_EN
            tx_d    = par_q;
            state_d = PARITY;
`else
            tx_d    = 1'b1;
            state_d = STOP;
`endif
          end else begin
            shift_d = {1'b0, shift_q[7:1]};
            tx_d    = shift_q[1];
            bit_d   = bit_q + 1'b1;
          end
        end
      end
`ifdef COMPUTIE_UART_TX_PARITY_EN
      PARITY: begin
        if (bit_end) begin
          tx_d    = 1'b1;
          state_d = STOP;
        end
      end
`endif
      STOP: begin
        // A waiting byte starts immediately so frames run back-to-back.
        if (bit_end) begin
          if (fifo_nonempty) begin
            pop     = 1'b1;
            shift_d = head;
`ifdef COMPUTIE_UART_TX_PARITY_EN
            par_d   = ^head;
`endif
            tx_d    = 1'b0;
            state_d = START;
          end else begin
            tx_d    = 1'b1;
            state_d = IDLE;
          end
        end
      end
      default: begin
        tx_d    = 1'b1;
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge comm_clock or negedge comm_reset_n) begin
    if (!comm_reset_n) begin
      state_q  <= IDLE;
      tmr_q    <= '0;
      bit_q    <= '0;
      tx_q     <= 1'b1;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      tmr_q    <= tmr_d;
      bit_q    <= bit_d;
      tx_q     <= tx_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  always_ff @(posedge comm_clock) begin
    shift_q <= shift_d;
`ifdef COMPUTIE_UART_TX_PARITY_EN
    par_q   <= par_d;
`endif
  end

endmodule
